serial_in_parallel_out_rx: RTL and testbench

//  Receive side of the 4-bit serial link: samples a bit-serial stream (one bit per qualified

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_out_reg.sv | 61 ++++++
 rtl/serial_in_parallel_out_rx.sv | 96 +++++++++
 tb/tb_serial_in_parallel_out_rx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and helpers for the serial-in/parallel-out receiver
// Purpose : FSM state encoding and counter width helper used by the receiver blocks.
// Contents: ST_IDLE, ST_SHIFT state constants; cnt_w() bit-counter width function.
package sipo_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// rtl/sipo_out_reg.sv - output holding register with valid/ready and sticky overrun
// Purpose : holds each completed word until the consumer takes it; a word that
//           arrives while the previous one is still held is dropped and flagged.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           i_word[WIDTH]         completed word (already bit-order mapped)
//           i_complete            strobe: i_word is a new complete word this cycle
//           i_ready               consumer accepts o_data when o_valid & i_ready
//           o_data[WIDTH]         held word
//           o_valid               word available
//           o_overrun             sticky drop flag, cleared only by reset
module sipo_out_reg #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_complete,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (i_complete) begin
         // A free slot, or one being emptied this cycle, takes the new word.
         if (!valid_q || i_ready) begin
            data_d  = i_word;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_overrun = ovr_q;

endmodule

// File: rtl/serial_in_parallel_out_rx.sv
// rtl/serial_in_parallel_out_rx.sv - framed bit-serial receiver assembling WIDTH-bit words
// Purpose : samples i_sin on each i_en strobe, frames words with i_sof, and hands
//           each complete word to the output holding register.
// Ports   : i_clk, i_rst          clock, synchronous active-high reset
//           i_sin, i_en, i_sof    serial bit, bit strobe, start-of-frame (qualified by i_en)
//           i_ready               consumer ready
//           o_data[WIDTH]         assembled word, stable while o_valid
//           o_valid               word available
//           o_busy                partial word in progress
//           o_overrun             sticky dropped-word flag
module serial_in_parallel_out_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sin,
   input  logic             i_en,
   input  logic             i_sof,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_overrun
);

   localparam int CW = cnt_w(WIDTH);

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;   // bit k of the frame lives at shift_q[k]
   logic             complete;
   logic [WIDTH-1:0] word_mapped;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      complete = 1'b0;
      if (i_en) begin
         if (i_sof) begin
            // Start of frame, or resync mid-word: previous partial word is discarded.
            shift_d    = '0;
            shift_d[0] = i_sin;
            cnt_d      = CW'(1);
            state_d    = ST_SHIFT;
         end else if (state_q == ST_SHIFT) begin
            shift_d[cnt_q] = i_sin;
            if (cnt_q == CW'(WIDTH - 1)) begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // The word offered on completion includes the bit sampled this cycle.
   always_comb begin
      word_mapped = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (LSB_FIRST != 0) word_mapped[k]           = shift_d[k];
         else                word_mapped[WIDTH-1-k]   = shift_d[k];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   assign o_busy = (state_q == ST_SHIFT);

   sipo_out_reg #(.WIDTH(WIDTH)) u_out (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_word     (word_mapped),
      .i_complete (complete),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_overrun  (o_overrun)
   );

endmodule

// File: tb/tb_serial_in_parallel_out_rx.sv
// tb/tb_serial_in_parallel_out_rx.sv - scoreboard bench for serial_in_parallel_out_rx
module tb_serial_in_parallel_out_rx;

   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, en = 1'b0, sof = 1'b0, sin = 1'b0, rdy = 1'b0;

   logic [W-1:0] l_data, m_data;
   logic         l_valid, l_busy, l_ovr, m_valid, m_busy, m_ovr;

   serial_in_parallel_out_rx #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_en(en), .i_sof(sof), .i_ready(rdy),
      .o_data(l_data), .o_valid(l_valid), .o_busy(l_busy), .o_overrun(l_ovr));

   serial_in_parallel_out_rx #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_en(en), .i_sof(sof), .i_ready(rdy),
      .o_data(m_data), .o_valid(m_valid), .o_busy(m_busy), .o_overrun(m_ovr));

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: frame bits collected in an array, word built arithmetically.
   int        cur[32];
   int        nb = 0;
   bit        mv = 0, movr = 0;
   int        q_l[$], q_m[$];
   bit        mon_en = 0;

   always @(posedge clk) begin
      bit complete;
      int wl, wm;
      complete = 0;
      if (rst) begin
         nb = 0; mv = 0; movr = 0;
         q_l.delete(); q_m.delete();
      end else begin
         if (en) begin
            if (sof) begin
               cur[0] = sin; nb = 1;
            end else if (nb > 0) begin
               cur[nb] = sin; nb++;
               if (nb == W) begin complete = 1; nb = 0; end
            end
         end
         if (complete && (!mv || rdy)) begin
            wl = 0; wm = 0;
            for (int k = 0; k < W; k++) begin
               wl += cur[k] * (2 ** k);
               wm += cur[k] * (2 ** (W - 1 - k));
            end
            q_l.push_back(wl); q_m.push_back(wm);
            mv = 1;
         end else if (complete) begin
            movr = 1;
         end else if (mv && rdy) begin
            mv = 0;
         end
      end
   end

   // Monitor: compares flags every cycle and the presented word against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("l_valid", l_valid, mv);
         chk("m_valid", m_valid, mv);
         chk("l_busy", l_busy, nb != 0);
         chk("m_busy", m_busy, nb != 0);
         chk("l_overrun", l_ovr, movr);
         chk("m_overrun", m_ovr, movr);
         if (l_valid) begin
            if (q_l.size() == 0) chk("l_data_unexpected", 1, 0);
            else begin
               chk("l_data", l_data, q_l[0]);
               if (rdy) void'(q_l.pop_front());
            end
         end
         if (m_valid) begin
            if (q_m.size() == 0) chk("m_data_unexpected", 1, 0);
            else begin
               chk("m_data", m_data, q_m[0]);
               if (rdy) void'(q_m.pop_front());
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic s, input logic d, input logic y);
      rst = r; en = e; sof = s; sin = d; rdy = y;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [W-1:0] bits, input int gap, input logic y);
      for (int k = 0; k < W; k++) begin
         step(1'b0, 1'b1, k == 0, bits[k], y);
         if (k < W - 1)
            for (int g = 0; g < gap; g++) begin
               step(1'b0, 1'b0, 1'b0, 1'b0, y);
               chk("busy_gap", l_busy, 1'b1);
            end
      end
   endtask

   initial begin
      // 1: reset while inputs toggle
      for (int i = 0; i < 3; i++) begin
         step(1'b1, i[0], 1'b1, ~i[0], 1'b1);
         mon_en = 1;
         chk("rst_outputs", {l_data, l_valid, l_busy, l_ovr}, 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_outputs", {l_data, l_valid, l_busy, l_ovr}, 0);

      // 2: contiguous frame 0,1,0,1
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("no_valid_before_last", l_valid, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t2_valid", l_valid, 1'b1);
      chk("t2_data", l_data, 4'b1010);
      chk("t2_mdata", m_data, 4'b0101);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_valid_one_cycle", l_valid, 1'b0);

      // 3: gapped frame 1,1,0,0
      frame(4'b0011, 2, 1'b1);
      chk("t3_data", l_data, 4'b0011);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 4: resync
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      frame(4'b0001, 0, 1'b1);
      chk("t4_data", l_data, 4'b0001);
      chk("t4_overrun", l_ovr, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 5: overrun with consumer stalled
      frame(4'hA, 0, 1'b0);
      frame(4'h5, 0, 1'b0);
      chk("t5_data_held", l_data, 4'hA);
      chk("t5_overrun", l_ovr, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_valid_drop", l_valid, 1'b0);
      chk("t5_overrun_sticky", l_ovr, 1'b1);

      // 6: MSB-first instance, then reset mid-word
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      frame(4'b0101, 0, 1'b1);
      chk("t6_mdata", m_data, 4'b1010);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t6_busy", m_busy, 1'b0);
      chk("t6_valid", m_valid, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++)
         step(($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
              1'($urandom), ($urandom % 4) != 0);

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      mon_en = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
